// File: rtl/downsampler_4x_box_pkg.sv
// Shared frame geometry and datapath widths for the 4x box downsampler / upsampler pair.
package downsampler_4x_box_pkg;

    localparam int unsigned NUMCOL  = 800;
    localparam int unsigned NUMROW  = 600;
    localparam int unsigned DW      = 8;
    localparam int unsigned CW      = 10;
    localparam int unsigned NUMCOL4 = NUMCOL / 4;
    localparam int unsigned ACCW    = DW + 4;

endpackage

// File: rtl/downsampler_4x_box_line_accum_ram.sv
// Line buffer of partial 4x4 block sums: one write port, registered read, no content reset.
module line_accum_ram
    import downsampler_4x_box_pkg::*;
#(
    parameter int unsigned DEPTH = NUMCOL4,
    parameter int unsigned W     = ACCW,
    parameter int unsigned AW    = 8
) (
    input  logic          clock,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Write-first is not needed: the address is held for several clocks before use.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/downsampler_4x_box.sv
// Reduces a raster pixel stream by 4x in both directions using a rounded 4x4 box mean.
module downsampler_4x_box
    import downsampler_4x_box_pkg::*;
#(
    parameter int unsigned NCOL = NUMCOL,
    parameter int unsigned NROW = NUMROW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid,
    input  logic [DW-1:0] data,
    input  logic          fifo_full,
    output logic          fifo_write,
    output logic [DW-1:0] dataout,
    output logic [CW-1:0] current_rowcount,
    output logic [CW-1:0] current_colcount,
    output logic          overflow
);

    localparam int unsigned NCOL4 = NCOL / 4;
    localparam int unsigned AW    = (NCOL4 > 1) ? $clog2(NCOL4) : 1;
    localparam int unsigned HW    = DW + 2;

    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_row;
    logic [HW-1:0]   r_hsum;
    logic            r_out_valid;
    logic            r_overflow;
    logic [DW-1:0]   r_dataout;

    logic [HW-1:0]   w_hsum_tot;
    logic [AW-1:0]   w_addr;
    logic            w_we;
    logic            w_blk_done;
    logic [ACCW-1:0] w_rd_data;
    logic [ACCW-1:0] w_sum16;
    logic [ACCW-1:0] w_wdata;

    assign w_hsum_tot = r_hsum + HW'(data);
    assign w_addr     = AW'(r_col >> 2);
    assign w_we       = valid && (r_col[1:0] == 2'd3);
    assign w_blk_done = w_we && (r_row[1:0] == 2'd3);
    assign w_sum16    = w_rd_data + ACCW'(w_hsum_tot);
    // First row of a block row overwrites, so stale entries never need clearing.
    assign w_wdata    = (r_row[1:0] == 2'd0) ? ACCW'(w_hsum_tot) : w_sum16;

    line_accum_ram #(
        .DEPTH (NCOL4),
        .W     (ACCW),
        .AW    (AW)
    ) u_line_accum_ram (
        .clock   (clock),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rd_data)
    );

    // Raster position of the next accepted pixel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid) begin
            if (r_col == CW'(NCOL - 1)) begin
                r_col <= '0;
                r_row <= (r_row == CW'(NROW - 1)) ? '0 : r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Horizontal sum of the first three pixels of each 4-pixel group.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hsum <= '0;
        end else if (valid) begin
            case (r_col[1:0])
                2'd0:    r_hsum <= HW'(data);
                2'd1,
                2'd2:    r_hsum <= w_hsum_tot;
                default: r_hsum <= r_hsum;
            endcase
        end
    end

    // Rounded block mean, one-cycle result strobe and sticky drop flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_dataout   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= w_blk_done;
            if (w_blk_done) begin
                r_dataout <= DW'((w_sum16 + ACCW'(8)) >> 4);
            end
            if (r_out_valid && fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The FIFO's full flag is judged in the same cycle as the write it gates.
    assign fifo_write       = r_out_valid & ~fifo_full;
    assign dataout          = r_dataout;
    assign current_rowcount = r_row;
    assign current_colcount = r_col;
    assign overflow         = r_overflow;

endmodule
